// File: rtl/matrix_pkg.sv
// Shared definitions for the LED-matrix pattern engine: operating modes and
// the XNOR LFSR tap table.
package matrix_pkg;

  localparam int unsigned MODE_W     = 2;
  localparam int unsigned LFSR_MAX_W = 256;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN    = 2'b00,
    MODE_FREEZE = 2'b01,
    MODE_STEP   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  // Builds a mask from up to four 1-based tap positions; 0 means unused.
  function automatic logic [LFSR_MAX_W-1:0] tap_mask(input int unsigned a, input int unsigned b,
                                                     input int unsigned c, input int unsigned d);
    logic [LFSR_MAX_W-1:0] m;
    m = '0;
    if (a != 0) m[8'(a - 1)] = 1'b1;
    if (b != 0) m[8'(b - 1)] = 1'b1;
    if (c != 0) m[8'(c - 1)] = 1'b1;
    if (d != 0) m[8'(d - 1)] = 1'b1;
    return m;
  endfunction

  // Maximal-length XNOR taps; zero return marks an unsupported width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned width);
    case (width)
      4:       return tap_mask(4, 3, 0, 0);
      6:       return tap_mask(6, 5, 0, 0);
      8:       return tap_mask(8, 6, 5, 4);
      9:       return tap_mask(9, 5, 0, 0);
      10:      return tap_mask(10, 7, 0, 0);
      12:      return tap_mask(12, 6, 4, 1);
      14:      return tap_mask(14, 5, 3, 1);
      15:      return tap_mask(15, 14, 0, 0);
      16:      return tap_mask(16, 15, 13, 4);
      18:      return tap_mask(18, 11, 0, 0);
      20:      return tap_mask(20, 17, 0, 0);
      21:      return tap_mask(21, 19, 0, 0);
      22:      return tap_mask(22, 21, 0, 0);
      24:      return tap_mask(24, 23, 22, 17);
      25:      return tap_mask(25, 22, 0, 0);
      26:      return tap_mask(26, 6, 2, 1);
      27:      return tap_mask(27, 5, 2, 1);
      28:      return tap_mask(28, 25, 0, 0);
      30:      return tap_mask(30, 6, 4, 1);
      32:      return tap_mask(32, 22, 2, 1);
      33:      return tap_mask(33, 20, 0, 0);
      35:      return tap_mask(35, 33, 0, 0);
      36:      return tap_mask(36, 25, 0, 0);
      39:      return tap_mask(39, 35, 0, 0);
      40:      return tap_mask(40, 38, 21, 19);
      42:      return tap_mask(42, 41, 20, 19);
      44:      return tap_mask(44, 43, 18, 17);
      45:      return tap_mask(45, 44, 42, 41);
      48:      return tap_mask(48, 47, 21, 20);
      49:      return tap_mask(49, 40, 0, 0);
      50:      return tap_mask(50, 49, 24, 23);
      52:      return tap_mask(52, 49, 0, 0);
      54:      return tap_mask(54, 53, 18, 17);
      55:      return tap_mask(55, 31, 0, 0);
      56:      return tap_mask(56, 55, 35, 34);
      60:      return tap_mask(60, 59, 0, 0);
      63:      return tap_mask(63, 62, 0, 0);
      64:      return tap_mask(64, 63, 61, 60);
      72:      return tap_mask(72, 66, 25, 19);
      80:      return tap_mask(80, 79, 43, 42);
      96:      return tap_mask(96, 94, 49, 47);
      100:     return tap_mask(100, 63, 0, 0);
      112:     return tap_mask(112, 110, 69, 67);
      128:     return tap_mask(128, 126, 101, 99);
      144:     return tap_mask(144, 143, 75, 74);
      256:     return tap_mask(256, 254, 251, 246);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci XNOR LFSR with seed load and a one-cycle pulse when an advance
// lands back on the loaded seed.
module lfsr_core
  import matrix_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         step_en,
  input  logic         load_en,
  input  logic [N-1:0] seed_data,
  output logic [N-1:0] state,
  output logic         done
);

  localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));

  if (N < 4 || N > LFSR_MAX_W || TAPS == '0) begin : g_bad_width
    $error("lfsr_core: no tap entry for width %0d", N);
  end

  logic [N-1:0] seed_q;
  logic [N-1:0] next_c;
  logic [N-1:0] load_val_c;

  // All-ones is the XNOR lockup state, so it is replaced by all-zeros.
  assign next_c     = {state[N-2:0], ~^(state & TAPS)};
  assign load_val_c = (&seed_data) ? '0 : seed_data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= '0;
      seed_q <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_en) begin
        state  <= load_val_c;
        seed_q <= load_val_c;
      end else if (step_en) begin
        state <= next_c;
        done  <= (next_c == seed_q);
      end
    end
  end

endmodule

// File: rtl/lfsr_matrix_scanner.sv
// ROWS x COLS LED-matrix pattern engine: prescaled LFSR pattern, frame latch
// updated only at frame wrap, and a row scanner driving registered outputs.
module lfsr_matrix_scanner
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned STEP_DIV   = 21,
  parameter bit          COL_ACT_LO = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [MODE_W-1:0]      mode,
  input  logic                   step_req,
  input  logic                   seed_valid,
  input  logic [ROWS*COLS-1:0]   seed_data,
  input  logic                   blank,
  output logic [ROWS-1:0]        rows,
  output logic [COLS-1:0]        columns,
  output logic                   frame_start,
  output logic                   lfsr_done,
  output logic                   led_step
);

  localparam int unsigned N      = ROWS * COLS;
  localparam int unsigned RIDX_W = $clog2(ROWS);

  if (ROWS < 2 || ROWS > 16 || COLS < 2 || COLS > 16 ||
      SCAN_DIV < 1 || STEP_DIV < SCAN_DIV) begin : g_bad_param
    $error("lfsr_matrix_scanner: unsupported parameter combination");
  end

  logic [STEP_DIV-1:0] presc_q;
  logic [RIDX_W-1:0]   row_q;
  logic                primed_q;
  logic [N-1:0]        frame_q;
  logic [N-1:0]        lfsr_state;
  logic                scan_tick_c;
  logic                step_tick_c;
  logic                wrap_c;
  logic                step_en_c;
  logic                load_en_c;
  logic [COLS-1:0]     row_cols_c;

  assign scan_tick_c = &presc_q[SCAN_DIV-1:0];
  assign step_tick_c = &presc_q;
  assign wrap_c      = (row_q == RIDX_W'(ROWS - 1));
  assign row_cols_c  = COLS'(frame_q >> (row_q * COLS));

  // Mode decode: only one LFSR event per cycle, STEP ignores the step tick.
  always_comb begin
    step_en_c = 1'b0;
    load_en_c = 1'b0;
    case (mode_e'(mode))
      MODE_RUN:    step_en_c = step_tick_c;
      MODE_FREEZE: step_en_c = 1'b0;
      MODE_STEP:   step_en_c = step_req;
      MODE_LOAD:   load_en_c = seed_valid;
      default:     step_en_c = 1'b0;
    endcase
  end

  lfsr_core #(.N(N)) u_lfsr (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .step_en   (step_en_c),
    .load_en   (load_en_c),
    .seed_data (seed_data),
    .state     (lfsr_state),
    .done      (lfsr_done)
  );

  // Prescaler, row scanner and tear-free frame latch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q  <= '0;
      row_q    <= '0;
      primed_q <= 1'b0;
      frame_q  <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (scan_tick_c) begin
        row_q    <= wrap_c ? '0 : row_q + 1'b1;
        primed_q <= 1'b1;
        if (wrap_c || !primed_q) frame_q <= lfsr_state;
      end
    end
  end

  // Output registers lag the row index by one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rows        <= '0;
      columns     <= {COLS{COL_ACT_LO}};
      frame_start <= 1'b0;
      led_step    <= 1'b0;
    end else begin
      rows        <= blank ? '0 : (ROWS'(1) << row_q);
      columns     <= row_cols_c ^ {COLS{COL_ACT_LO}};
      frame_start <= scan_tick_c && wrap_c;
      led_step    <= led_step ^ step_en_c;
    end
  end

endmodule

// File: tb/tb_lfsr_matrix_scanner.sv
// Randomised self-checking bench for lfsr_matrix_scanner (4x4, fast dividers)
// against an edge-count based reference model.
module tb_lfsr_matrix_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int N        = 16;
  localparam int SCAN_DIV = 2;
  localparam int STEP_DIV = 4;
  localparam int SCAN_P   = 1 << SCAN_DIV;
  localparam int STEP_P   = 1 << STEP_DIV;
  // Taps 16,15,13,4 as a bit mask.
  localparam logic [N-1:0] TAPS = 16'hD008;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b1;
  logic [1:0]      mode = 2'b00;
  logic            step_req = 1'b0;
  logic            seed_valid = 1'b0;
  logic [N-1:0]    seed_data = '0;
  logic            blank = 1'b0;
  logic [ROWS-1:0] rows;
  logic [COLS-1:0] columns;
  logic            frame_start;
  logic            lfsr_done;
  logic            led_step;

  int n_pass = 0;
  int n_total = 0;

  lfsr_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .STEP_DIV(STEP_DIV), .COL_ACT_LO(1'b1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .mode(mode), .step_req(step_req), .seed_valid(seed_valid),
    .seed_data(seed_data), .blank(blank), .rows(rows), .columns(columns),
    .frame_start(frame_start), .lfsr_done(lfsr_done), .led_step(led_step)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s);
    int ones = 0;
    for (int i = 0; i < N; i++) if (TAPS[i] && s[i]) ones++;
    return {s[N-2:0], (ones % 2 == 0)};
  endfunction

  // Reference model: k counts clock edges since reset release.
  int unsigned     k;
  int unsigned     m_e;
  int unsigned     m_row;
  logic            m_adv;
  logic [N-1:0]    m_lfsr, m_seed, m_frame;
  logic [ROWS-1:0] e_rows;
  logic [COLS-1:0] e_cols;
  logic            e_fs, e_done, e_led;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k = 0; m_lfsr = '0; m_seed = '0; m_frame = '0;
      e_rows = '0; e_cols = '1; e_fs = 1'b0; e_done = 1'b0; e_led = 1'b0;
    end else begin
      m_e    = k + 1;
      m_row  = (k / SCAN_P) % ROWS;
      e_rows = blank ? '0 : ROWS'(1 << m_row);
      e_cols = ~m_frame[m_row*COLS +: COLS];
      e_fs   = (m_e % SCAN_P == 0) && ((m_e / SCAN_P) % ROWS == 0);
      if ((m_e % SCAN_P == 0) && (e_fs || m_e == SCAN_P)) m_frame = m_lfsr;
      m_adv  = (mode == 2'b00 && (m_e % STEP_P == 0)) || (mode == 2'b10 && step_req);
      e_done = 1'b0;
      if (mode == 2'b11 && seed_valid) begin
        m_lfsr = (seed_data == '1) ? '0 : seed_data;
        m_seed = m_lfsr;
      end else if (m_adv) begin
        m_lfsr = lfsr_next(m_lfsr);
        e_done = (m_lfsr == m_seed);
        e_led  = ~e_led;
      end
      k++;
    end
  end

  always @(negedge CLK) begin
    chk("rows", 32'(rows), 32'(e_rows));
    chk("columns", 32'(columns), 32'(e_cols));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("lfsr_done", 32'(lfsr_done), 32'(e_done));
    chk("led_step", 32'(led_step), 32'(e_led));
  end

  // Event counters sampled away from the active edge.
  logic led_prev = 1'b0;
  int   led_toggles = 0;
  int   done_pulses = 0;
  always @(negedge CLK) begin
    if (led_step !== led_prev) led_toggles++;
    led_prev = led_step;
    if (lfsr_done === 1'b1) done_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!frame_start && n < 64);
    if (!frame_start) n = -1;
  endtask

  task automatic read_frame(output logic [N-1:0] f);
    int n;
    f = '0;
    wait_fs(n);
    chk("frame_wait", 32'(n > 0), 32'd1);
    repeat (ROWS * SCAN_P) begin
      @(negedge CLK);
      for (int r = 0; r < ROWS; r++) if (rows == ROWS'(1 << r)) f[r*COLS +: COLS] = ~columns;
    end
  endtask

  task automatic load_seed(input logic [N-1:0] s);
    mode = 2'b11; seed_data = s; seed_valid = 1'b1;
    tick(1);
    seed_valid = 1'b0; mode = 2'b01;
  endtask

  initial begin
    logic [N-1:0] f;
    int n, base;
    logic [15:0] seen;

    #1 RST_N = 1'b0;
    @(negedge CLK);
    chk("reset_rows", 32'(rows), 32'h0);
    chk("reset_columns", 32'(columns), 32'hF);
    @(negedge CLK);
    RST_N = 1'b1;

    // RUN from reset: one-hot rows every SCAN_P cycles, frame_start every 16.
    wait_fs(n);
    chk("first_frame_start", 32'(n), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      if (i % 4 == 1) chk("row_sequence", 32'(rows), 32'(1 << (i / 4)));
      if (i == 16) chk("frame_period", 32'(frame_start), 32'd1);
    end

    // Seed load then freeze.
    tick(1);
    load_seed(16'h0001);
    read_frame(f);
    chk("frame_seed1", 32'(f), 32'h0001);
    n = 0;
    do begin @(negedge CLK); n++; end while (rows != 4'b0001 && n < 32);
    chk("row0_columns", 32'(columns), 32'hE);

    // Single-step: exactly three advances.
    tick(1);
    base = led_toggles;
    mode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      tick(1);
      step_req = 1'b0;
      tick(int'($urandom_range(1, 5)));
    end
    mode = 2'b01;
    tick(2);
    chk("led_toggles", 32'(led_toggles - base), 32'd3);
    read_frame(f);
    chk("frame_step3", 32'(f), 32'h000F);

    // Randomised modes, pulses, seeds and blanking.
    tick(1);
    mode = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      step_req   = ($urandom_range(0, 2) == 0);
      seed_valid = ($urandom_range(0, 3) == 0);
      seed_data  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      blank      = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    step_req = 1'b0; seed_valid = 1'b0; blank = 1'b0;

    // All-ones seed maps to all-zeros.
    load_seed(16'hFFFF);
    read_frame(f);
    chk("frame_lockup_seed", 32'(f), 32'h0000);

    // Blanking keeps rows off while columns keep scanning.
    tick(1);
    load_seed(16'h1234);
    read_frame(f);
    chk("frame_1234", 32'(f), 32'h1234);
    blank = 1'b1;
    @(negedge CLK);
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("blank_rows", 32'(rows), 32'h0);
      seen[columns] = 1'b1;
    end
    chk("blank_columns_seen", 32'(seen), 32'h7800);
    blank = 1'b0;

    // Full period from seed 0x0001 in STEP mode, one advance per cycle.
    tick(1);
    load_seed(16'h0001);
    tick(1);
    base = done_pulses;
    mode = 2'b10; step_req = 1'b1;
    tick(65535);
    step_req = 1'b0; mode = 2'b01;
    tick(2);
    chk("done_pulses", 32'(done_pulses - base), 32'd1);
    chk("model_period", 32'(m_lfsr), 32'h0001);
    read_frame(f);
    chk("frame_after_period", 32'(f), 32'h0001);

    // Reset asserted mid-frame.
    tick(1);
    mode = 2'b00;
    tick(7);
    #1 RST_N = 1'b0;
    #1;
    chk("midreset_rows", 32'(rows), 32'h0);
    chk("midreset_columns", 32'(columns), 32'hF);
    chk("midreset_fs", 32'(frame_start), 32'h0);
    chk("midreset_done", 32'(lfsr_done), 32'h0);
    chk("midreset_led", 32'(led_step), 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("restart_row0", 32'(rows), 32'h1);
    wait_fs(n);
    chk("restart_frame_start", 32'(n), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
